// File: rtl/systolic_feeder.sv
// Operand feeder for an MxP systolic array: buffers A (MxK) and B (KxP) from a
// single load stream, then replays them diagonally skewed onto the row/column lanes.
module systolic_feeder #(
  parameter int M        = 4,
  parameter int P        = 4,
  parameter int K        = 4,
  parameter int BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iValid,
  input  logic [BITWIDTH-1:0]   iData,
  output logic                  oReady,
  input  logic                  iStart,
  output logic [M*BITWIDTH-1:0] oRow,
  output logic [P*BITWIDTH-1:0] oCol,
  output logic                  oPeClear,
  output logic                  oFeedValid,
  output logic                  oDone,
  output logic [2:0]            oState
);

  // Handshake: an element moves when iValid && oReady on a rising edge; oReady
  // depends only on state, never on iValid, and iData must be stable while iValid is high.
  localparam int N    = M*K + K*P;
  localparam int F    = K + ((M > P) ? M : P) - 1;
  localparam int D    = M + P - 1;
  localparam int CMAX = (N > F) ? ((N > D) ? N : D) : ((F > D) ? F : D);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(N);

  typedef enum logic [2:0] {S_LOAD, S_FULL, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt, r_t;
  logic [BITWIDTH-1:0]   r_buf [N];
  logic [M*BITWIDTH-1:0] r_row, w_row;
  logic [P*BITWIDTH-1:0] r_col, w_col;
  logic [IW-1:0]         w_aidx [M];
  logic [IW-1:0]         w_bidx [P];
  logic                  w_accept, w_load_last, w_feed_last, w_drain_last, w_stage;
  int                    w_step;

  assign w_accept     = (r_state == S_LOAD) && iValid;
  assign w_load_last  = (r_cnt == CW'(N - 1));
  assign w_feed_last  = (r_t == CW'(F - 1));
  assign w_drain_last = (r_t == CW'(D - 1));

  // Outputs are registered, so the lanes are staged one step ahead of FEED.
  assign w_stage = (r_state == S_CLEAR) || ((r_state == S_FEED) && !w_feed_last);
  assign w_step  = (r_state == S_CLEAR) ? 0 : int'(r_t) + 1;

  always_comb begin
    w_row = '0;
    w_col = '0;
    for (int i = 0; i < M; i++) begin
      w_aidx[i] = IW'(i*K + w_step - i);
      if (w_stage && (w_step >= i) && (w_step - i < K))
        w_row[(M-i-1)*BITWIDTH +: BITWIDTH] = r_buf[w_aidx[i]];
    end
    for (int j = 0; j < P; j++) begin
      w_bidx[j] = IW'(M*K + (w_step - j)*P + j);
      if (w_stage && (w_step >= j) && (w_step - j < K))
        w_col[(P-j-1)*BITWIDTH +: BITWIDTH] = r_buf[w_bidx[j]];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && w_load_last) w_next = S_FULL;
      S_FULL:  if (iStart) w_next = S_CLEAR;
      S_CLEAR: w_next = S_FEED;
      S_FEED:  if (w_feed_last) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next = S_DONE;
      S_DONE:  w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_t     <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next;
      r_row   <= w_row;
      r_col   <= w_col;
      if (w_accept)
        r_cnt <= r_cnt + CW'(1);
      else if (r_state == S_DONE)
        r_cnt <= '0;
      case (r_state)
        S_FEED:  r_t <= w_feed_last ? '0 : r_t + CW'(1);
        S_DRAIN: r_t <= w_drain_last ? '0 : r_t + CW'(1);
        default: r_t <= '0;
      endcase
    end
  end

  // Operand storage carries no reset; a new load overwrites every entry.
  always_ff @(posedge clk) begin
    if (!reset && w_accept)
      r_buf[r_cnt[IW-1:0]] <= iData;
  end

  assign oReady     = (r_state == S_LOAD);
  assign oPeClear   = (r_state == S_CLEAR);
  assign oFeedValid = (r_state == S_FEED);
  assign oDone      = (r_state == S_DONE);
  assign oRow       = r_row;
  assign oCol       = r_col;
  assign oState     = r_state;

endmodule
